// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package if_pkg;

  localparam int unsigned AW_DEF       = 9;
  localparam int unsigned DW_DEF       = 32;
  localparam int unsigned RESET_PC_DEF = 0;
  localparam logic [15:0] COUNT_MAX    = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD    = 2'd0,
    PC_INCR    = 2'd1,
    PC_BRANCH  = 2'd2,
    PC_RESTART = 2'd3
  } pc_sel_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == COUNT_MAX) begin
      result = COUNT_MAX;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/if_pc_next.sv
// Combinational next-PC selector: hold, increment (wraps modulo 2^AW), branch or restart.
module if_pc_next
  import if_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  pc_sel_t          sel,
  input  logic [AW-1:0]    pc,
  input  logic [AW-1:0]    branch_target,
  output logic [AW-1:0]    pc_next
);

  localparam logic [AW-1:0] PC_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PC_RESET = RESET_PC[AW-1:0];

  // Select the PC value for the next cycle.
  always_comb begin
    pc_next = pc;
    case (sel)
      PC_HOLD:    pc_next = pc;
      PC_INCR:    pc_next = pc + PC_ONE;
      PC_BRANCH:  pc_next = branch_target;
      PC_RESTART: pc_next = PC_RESET;
      default:    pc_next = pc;
    endcase
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: IDLE/FETCH/HALT FSM driving a combinational instruction memory.
// Optional macro IF_FETCH_BOUND_CHECK_EN halts fetching once PC leaves 0..PROG_LEN-1.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned PROG_LEN = 45,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_valid,
  input  logic [AW-1:0] branch_target,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_instr,
  output logic          if_valid,
  output logic [DW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  output logic          halted,
  output logic [15:0]   fetch_count
);

  localparam logic [AW-1:0] PC_RESET = RESET_PC[AW-1:0];

`ifdef IF_FETCH_BOUND_CHECK_EN
  localparam logic BOUND_EN = 1'b1;
`else
  localparam logic BOUND_EN = 1'b0;
`endif

  fetch_state_t  state;
  fetch_state_t  state_next;
  pc_sel_t       pc_sel;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next;
  logic [31:0]   pc_ext;
  logic          out_of_range;
  logic          do_fetch;
  logic          do_flush;
  logic          do_restart;
  logic          do_halt;

  assign mem_addr     = pc;
  assign pc_ext       = 32'(pc);
  assign out_of_range = BOUND_EN & (pc_ext >= PROG_LEN);

  if_pc_next #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc_next (
    .sel           (pc_sel),
    .pc            (pc),
    .branch_target (branch_target),
    .pc_next       (pc_next)
  );

  // Next-state and per-cycle action decode.
  always_comb begin
    state_next = state;
    pc_sel     = PC_HOLD;
    do_fetch   = 1'b0;
    do_flush   = 1'b0;
    do_restart = 1'b0;
    do_halt    = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_next = ST_FETCH;
          pc_sel     = PC_RESTART;
          do_restart = 1'b1;
        end else begin
          state_next = state;
        end
      end
      ST_FETCH: begin
        // A redirect wins over stall so the flush is never lost.
        if (branch_valid) begin
          pc_sel   = PC_BRANCH;
          do_flush = 1'b1;
        end else if (stall) begin
          pc_sel = PC_HOLD;
        end else if (out_of_range) begin
          state_next = ST_HALT;
          do_halt    = 1'b1;
        end else begin
          pc_sel   = PC_INCR;
          do_fetch = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        pc_sel     = PC_RESTART;
      end
    endcase
  end

  // State, PC and fetch-output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= PC_RESET;
      if_valid    <= 1'b0;
      if_instr    <= {DW{1'b0}};
      if_pc       <= {AW{1'b0}};
      halted      <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (do_restart) begin
        if_valid    <= 1'b0;
        halted      <= 1'b0;
        fetch_count <= 16'd0;
      end else if (do_halt) begin
        if_valid <= 1'b0;
        halted   <= 1'b1;
      end else if (do_flush) begin
        if_valid <= 1'b0;
      end else if (do_fetch) begin
        if_instr    <= mem_instr;
        if_pc       <= pc;
        if_valid    <= 1'b1;
        fetch_count <= sat_inc16(fetch_count);
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: directed stimulus pushes expected fetches, a monitor pops them.
module tb_if_fetch_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          stall;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_instr;
  logic          if_valid;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          halted;
  logic [15:0]   fetch_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic [15:0]   cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'h3C, 7'h55, a, 8'hA5};
  endfunction

  assign mem_instr = instr_of(mem_addr);

  if_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .mem_addr      (mem_addr),
    .mem_instr     (mem_instr),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; if a fetch is expected from this edge, queue it.
  task automatic cyc(input bit v, input logic [AW-1:0] p, input logic [15:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    if (v) begin
      e.pc    = p;
      e.instr = instr_of(p);
      e.cnt   = c;
      sb.push_back(e);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_if_valid"},    32'(if_valid),    32'd0);
    chk({tag, "_if_instr"},    32'(if_instr),    32'd0);
    chk({tag, "_if_pc"},       32'(if_pc),       32'd0);
    chk({tag, "_halted"},      32'(halted),      32'd0);
    chk({tag, "_fetch_count"}, 32'(fetch_count), 32'd0);
    chk({tag, "_mem_addr"},    32'(mem_addr),    32'd0);
  endtask

  // Monitor: every cycle the DUT presents a valid fetch, compare against the scoreboard head.
  always @(negedge clk) begin
    if (if_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: if_pc=%0d with empty scoreboard", if_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("if_pc",       32'(if_pc),       32'(mon_e.pc));
        chk("if_instr",    32'(if_instr),    32'(mon_e.instr));
        chk("fetch_count", 32'(fetch_count), 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    stall         = 1'b0;
    branch_valid  = 1'b0;
    branch_target = '0;
    cyc(1'b0, '0, 16'd0);
    cyc(1'b0, '0, 16'd0);
    chk_reset_state("reset");

    reset = 1'b0;
    start = 1'b1;
    cyc(1'b0, '0, 16'd0);
    start = 1'b0;
    chk("start_mem_addr", 32'(mem_addr), 32'd0);
    chk("start_if_valid", 32'(if_valid), 32'd0);

    for (int i = 0; i < 5; i++) cyc(1'b1, AW'(i), 16'(i + 1));

    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 9'd4, 16'd5);
      chk("stall_mem_addr", 32'(mem_addr), 32'd5);
    end
    stall = 1'b0;
    for (int i = 5; i < 10; i++) cyc(1'b1, AW'(i), 16'(i + 1));

    branch_valid  = 1'b1;
    branch_target = 9'd20;
    stall         = 1'b1;
    cyc(1'b0, '0, 16'd0);
    branch_valid  = 1'b0;
    stall         = 1'b0;
    chk("flush_if_valid",    32'(if_valid),    32'd0);
    chk("flush_mem_addr",    32'(mem_addr),    32'd20);
    chk("flush_if_pc",       32'(if_pc),       32'd9);
    chk("flush_fetch_count", 32'(fetch_count), 32'd10);
    cyc(1'b1, 9'd20, 16'd11);
    cyc(1'b1, 9'd21, 16'd12);

    start = 1'b1;
    cyc(1'b1, 9'd22, 16'd13);
    start = 1'b0;

    branch_valid  = 1'b1;
    branch_target = 9'd511;
    cyc(1'b0, '0, 16'd0);
    branch_valid  = 1'b0;
    chk("br511_mem_addr", 32'(mem_addr), 32'd511);
    chk("br511_if_valid", 32'(if_valid), 32'd0);

`ifndef IF_FETCH_BOUND_CHECK_EN
    cyc(1'b1, 9'd511, 16'd14);
    cyc(1'b1, 9'd0,   16'd15);
    cyc(1'b1, 9'd1,   16'd16);
    chk("wrap_halted",   32'(halted),   32'd0);
    chk("wrap_mem_addr", 32'(mem_addr), 32'd2);
`else
    cyc(1'b0, '0, 16'd0);
    chk("oob_halted",      32'(halted),      32'd1);
    chk("oob_if_valid",    32'(if_valid),    32'd0);
    chk("oob_fetch_count", 32'(fetch_count), 32'd13);
    stall         = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 9'd3;
    cyc(1'b0, '0, 16'd0);
    stall         = 1'b0;
    branch_valid  = 1'b0;
    chk("halt_hold_mem_addr", 32'(mem_addr), 32'd511);
    chk("halt_hold_halted",   32'(halted),   32'd1);
    start = 1'b1;
    cyc(1'b0, '0, 16'd0);
    start = 1'b0;
    chk("restart_halted",   32'(halted),      32'd0);
    chk("restart_count",    32'(fetch_count), 32'd0);
    chk("restart_mem_addr", 32'(mem_addr),    32'd0);
    for (int i = 0; i < 45; i++) cyc(1'b1, AW'(i), 16'(i + 1));
    cyc(1'b0, '0, 16'd0);
    chk("end_halted",      32'(halted),      32'd1);
    chk("end_if_valid",    32'(if_valid),    32'd0);
    chk("end_fetch_count", 32'(fetch_count), 32'd45);
    chk("end_mem_addr",    32'(mem_addr),    32'd45);
    start = 1'b1;
    cyc(1'b0, '0, 16'd0);
    start = 1'b0;
    chk("restart2_count",    32'(fetch_count), 32'd0);
    chk("restart2_mem_addr", 32'(mem_addr),    32'd0);
    chk("restart2_halted",   32'(halted),      32'd0);
    cyc(1'b1, 9'd0, 16'd1);
    cyc(1'b1, 9'd1, 16'd2);
`endif

    reset         = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 9'd7;
    stall         = 1'b1;
    start         = 1'b1;
    cyc(1'b0, '0, 16'd0);
    reset = 1'b0;
    start = 1'b0;
    chk_reset_state("midreset");

    cyc(1'b0, '0, 16'd0);
    chk("idle_ignore_mem_addr", 32'(mem_addr), 32'd0);
    chk("idle_ignore_if_valid", 32'(if_valid), 32'd0);
    branch_valid = 1'b0;
    stall        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected fetches never seen, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter AW, 9, instruction memory word-address width.
REQ-002 Parameter DW, 32, instruction width.
REQ-003 Parameter PROG_LEN, 45, number of valid program words (addresses 0..PROG_LEN-1).
REQ-004 Parameter RESET_PC, 0, PC loaded at reset and on restart.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin/restart fetching from RESET_PC.
REQ-008 stall  input  1  downstream not ready; hold all fetch state.
REQ-009 branch_valid  input  1  redirect request from execute stage.
REQ-010 branch_target  input  AW  redirect word address.
REQ-011 mem_addr  output  AW  address to combinational instruction memory.
REQ-012 mem_instr  input  DW  instruction word returned for mem_addr, same cycle.
REQ-013 if_valid  output  1  if_instr/if_pc hold a valid fetched instruction.
REQ-014 if_instr  output  DW  registered fetched instruction.
REQ-015 if_pc  output  AW  address if_instr was fetched from.
REQ-016 halted  output  1  fetch stopped (HALT state).
REQ-017 fetch_count  output  16  number of instructions delivered since reset/start.

Function
REQ-018 mem_addr SHALL equal the internal PC register combinationally at all times.
REQ-019 FSM states IDLE, FETCH, HALT; IDLE->FETCH on start; HALT->FETCH on start; any state->IDLE on reset.
REQ-020 start in FETCH SHALL be ignored; branch_valid and stall in IDLE/HALT SHALL be ignored.
REQ-021 In FETCH with stall=0, branch_valid=0: if_instr<=mem_instr, if_pc<=PC, if_valid<=1, PC<=PC+1, fetch_count<=fetch_count+1.
REQ-022 Latency: word at mem_addr appears on if_instr exactly one cycle later.
REQ-023 In FETCH with stall=1, branch_valid=0: PC, if_instr, if_pc, if_valid, fetch_count SHALL hold.
REQ-024 In FETCH with branch_valid=1 (regardless of stall): PC<=branch_target, if_valid<=0 (flush), if_instr/if_pc hold, fetch_count holds.
REQ-025 PC increment SHALL wrap modulo 2^AW (511+1 -> 0).
REQ-026 fetch_count SHALL saturate at 0xFFFF; cleared to 0 on transition IDLE/HALT->FETCH.
REQ-027 On start from IDLE/HALT: PC<=RESET_PC, if_valid<=0, halted<=0.
REQ-028 In HALT: if_valid=0, halted=1, PC holds.

Reset
REQ-029 On reset: state=IDLE, PC=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, fetch_count=0.
REQ-030 Reset asserted mid-FETCH SHALL override stall, branch_valid and start in that cycle.

Configuration
REQ-031 Macro IF_FETCH_BOUND_CHECK_EN defined: in FETCH with stall=0, branch_valid=0 and PC>=PROG_LEN, SHALL go to HALT instead of fetching (no if_valid, no count); branch to target>=PROG_LEN halts on the following non-stalled cycle.
REQ-032 Macro undefined: no bound check; PC runs freely with wrap, HALT reachable only never (halted stays 0).

Structure
REQ-033 Shared package if_pkg SHALL hold AW, DW defaults, RESET_PC default and the FSM state enum type.
REQ-034 Next-PC selection (branch/increment/hold/restart) SHALL be one combinational sub-module if_pc_next; FSM and registers stay in if_fetch_ctrl.

Verification
REQ-035 reset, start, no stall, mem=addr-indexed pattern -> if_pc 0,1,2,... on consecutive cycles, if_instr=mem[if_pc], fetch_count increments by 1 per cycle.
REQ-036 stall high 3 cycles at PC=5 -> if_pc=4, if_instr, fetch_count frozen 3 cycles; PC resumes at 5.
REQ-037 branch_valid=1, target=20, with stall=1 same cycle -> next cycle if_valid=0, mem_addr=20; following cycle if_pc=20.
REQ-038 With IF_FETCH_BOUND_CHECK_EN, run from 0 -> last if_pc=44, next cycle halted=1, if_valid=0, fetch_count=45; start -> restart at 0, count cleared.
REQ-039 Without macro, branch to 511 -> if_pc 511 then 0 (wrap), halted stays 0.
REQ-040 reset asserted mid-FETCH with branch_valid=1 -> next cycle state IDLE, all outputs at reset values, mem_addr=RESET_PC.
